countdown_timer: RTL
====================

Name: countdown_timer

Overview:
- MM:SS countdown timer; the count-down counterpart of the team's up-counting mm:ss stopwatch.
- A preset is loaded from BCD switch inputs and decremented once per second to 00:00, where the block stops and raises done.
- Driven by the two board push buttons. It outputs four BCD digits for the board's existing seven-segment decode stage.

Parameters:
- TICK_DIV, 50000000, CLOCK_50 cycles per one-second decrement (benches use 4).
- DEFAULT_MT, 0, minute-tens digit after reset.
- DEFAULT_MO, 5, minute-ones digit after reset.
- DEFAULT_ST, 0, second-tens digit after reset.
- DEFAULT_SO, 0, second-ones digit after reset.
- DEBOUNCE_CYC, 1000000, stable cycles required per key level (optional feature only).

Ports:
- CLOCK_50 input 1 system clock; sole clock.
- RESET input 1 synchronous, active-high reset.
- KEY input 2 active-low push buttons, asynchronous; KEY[0] = load, KEY[1] = start/pause.
- LOAD_MT input 4 BCD minute-tens preset.
- LOAD_MO input 4 BCD minute-ones preset.
- LOAD_ST input 4 BCD second-tens preset.
- LOAD_SO input 4 BCD second-ones preset.
- MT output 4 current minute-tens digit.
- MO output 4 current minute-ones digit.
- ST output 4 current second-tens digit.
- SO output 4 current second-ones digit.
- RUNNING output 1 high while in RUN.
- DONE output 1 high while in DONE.

Behaviour:
- Interface: one clock, CLOCK_50; RESET is synchronous and active-high. All state is registered on posedge CLOCK_50.
- Reset values: digits = DEFAULT_*; state IDLE; prescaler 0; RUNNING 0; DONE 0; key synchroniser and edge registers = 1 (released).
- Key path:
  - Each KEY bit passes through a 2-flop synchroniser, then a previous-level register.
  - A press is a 1->0 transition of the synchronised level, one cycle wide.
  - The state or digit effect is visible 3 cycles after the pin falls.
  - Held keys produce no repeat.
- States and transitions:
  - IDLE: KEY1 press -> RUN if digits != 00:00, else stay IDLE.
  - RUN: KEY1 press -> PAUSE.
  - PAUSE: KEY1 press -> RUN; prescaler retained, not cleared.
  - DONE: KEY1 press ignored.
- KEY0 press, any state: load digits from LOAD_*, clear prescaler, go to IDLE, DONE -> 0.
- Load clamping: ones digits > 9 load 9; tens digits > 5 load 5.
- Prescaler:
  - Counts only in RUN, from 0 to TICK_DIV-1, then wraps to 0 and fires a tick.
  - The first decrement occurs exactly TICK_DIV cycles after entering RUN from IDLE.
- Decrement (one per tick), as a BCD borrow chain:
  - SO 0 -> 9 with borrow; ST 0 -> 5 with borrow; MO 0 -> 9 with borrow.
  - MT 0 is never reached with a pending borrow, because 00:00 is never decremented.
- Completion:
  - A tick that produces 00:00 moves the state to DONE in the same edge.
  - RUNNING falls and DONE rises in that cycle. DONE holds until KEY0 press or RESET.
  - Digits remain 00:00 and no wrap to 59:59 ever occurs.
- Priority for simultaneous events: RESET > KEY0 > tick > KEY1.
  - KEY0 together with KEY1: KEY1 is discarded.
  - KEY0 on a tick cycle: load wins; no decrement.
  - KEY1 (pause) on a tick cycle: the decrement is applied, then PAUSE.
  - KEY1 on the cycle the tick reaches 00:00: DONE wins.
- RESET mid-run: returns to IDLE with DEFAULT_* digits on the next edge; any in-flight key press is lost.
- Maximum preset 59:59; digits are always valid BCD.

Optional Feature:
- COUNTDOWN_DEBOUNCE_EN defined:
  - After synchronisation, each key's accepted level changes only after the raw synchronised level differs from it for DEBOUNCE_CYC consecutive cycles.
  - Edge detection runs on the accepted level, so press latency is DEBOUNCE_CYC+3 cycles.
  - Bounces shorter than DEBOUNCE_CYC produce no press.
- Not defined: no debounce logic is instantiated and the latency is 3 cycles. DEBOUNCE_CYC is unused.

Decomposition:
- Shared package countdown_pkg:
  - State enum (IDLE, RUN, PAUSE, DONE).
  - BCD digit typedef (4-bit).
  - Constants BCD_MAX_ONES=9 and BCD_MAX_TENS=5.
- Sub-module bcd_down_digit, instantiated four times and chained by borrow.
  - Inputs: load, load value, max value, dec_in.
  - Outputs: digit, borrow_out (asserted when dec_in and digit==0).

Test Plan:
- RESET with defaults -> digits 05:00, RUNNING=0, DONE=0, state IDLE.
- Load 00:03, KEY1 press, TICK_DIV=4 -> digits read 00:02, 00:01, 00:00 at 4, 8 and 12 cycles after RUN entry. DONE=1 and RUNNING=0 at 00:00; digits hold 00:00 for 100 further cycles.
- Load 01:00, run one tick -> 00:59. Load 10:00, run one tick -> 09:59, with borrow across all digits.
- Pause/resume: run 00:10, press KEY1 at prescaler=2 -> PAUSE. Hold 50 cycles -> no change. Press KEY1 again -> next decrement after exactly 2 more cycles.
- Preset 00:00 with KEY1 press -> stays IDLE, RUNNING=0. Load LOAD_ST=7, LOAD_SO=12 -> digits 00:59.
- Same-cycle KEY0+KEY1 during RUN -> IDLE with loaded value. With COUNTDOWN_DEBOUNCE_EN and DEBOUNCE_CYC=8: a 5-cycle glitch on KEY[1] produces no press; a 20-cycle press is accepted after 11 cycles.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX_ONES = 4'd9;
    localparam bcd_t BCD_MAX_TENS = 4'd5;

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD digit of the countdown: clamped load, decrement with wrap-to-max and borrow out.
module bcd_down_digit
    import countdown_pkg::*;
#(
    parameter bcd_t RST_VAL = 4'd0
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic [3:0] max_val,
    input  logic       dec_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    function automatic logic [3:0] sat_bcd(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            digit <= RST_VAL;
        end else if (load) begin
            digit <= sat_bcd(load_val, max_val);
        end else if (dec_in) begin
            digit <= (digit == 4'd0) ? max_val : digit - 4'd1;
        end
    end

    assign borrow_out = dec_in && (digit == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer driven by two push buttons; optional key debounce under
// COUNTDOWN_DEBOUNCE_EN.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICK_DIV     = 50000000,
    parameter int DEFAULT_MT   = 0,
    parameter int DEFAULT_MO   = 5,
    parameter int DEFAULT_ST   = 0,
    parameter int DEFAULT_SO   = 0,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [1:0] KEY,
    input  logic [3:0] LOAD_MT,
    input  logic [3:0] LOAD_MO,
    input  logic [3:0] LOAD_ST,
    input  logic [3:0] LOAD_SO,
    output logic [3:0] MT,
    output logic [3:0] MO,
    output logic [3:0] ST,
    output logic [3:0] SO,
    output logic       RUNNING,
    output logic       DONE
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [1:0]    key_p0, key_p1, key_lvl, key_p2;
    logic [1:0]    press;
    logic [PW-1:0] presc;
    logic          tick, last_sec, nonzero;
    logic          so_b, st_b, mo_b, unused_mt_borrow;
    state_t        state;

    // Stage p0/p1: two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            key_p0 <= 2'b11;
            key_p1 <= 2'b11;
        end else begin
            key_p0 <= KEY;
            key_p1 <= key_p0;
        end
    end

`ifdef COUNTDOWN_DEBOUNCE_EN
    localparam int DCW = $clog2(DEBOUNCE_CYC + 1);
    logic [DCW-1:0] db_cnt [2];

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            key_lvl <= 2'b11;
            for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (key_p1[k] != key_lvl[k]) begin
                    if (db_cnt[k] == DCW'(DEBOUNCE_CYC - 1)) begin
                        key_lvl[k] <= key_p1[k];
                        db_cnt[k]  <= '0;
                    end else begin
                        db_cnt[k] <= db_cnt[k] + 1'b1;
                    end
                end else begin
                    db_cnt[k] <= '0;
                end
            end
        end
    end
`else
    logic unused_debounce;
    assign unused_debounce = (DEBOUNCE_CYC > 0);
    assign key_lvl = key_p1;
`endif

    // Stage p2: previous accepted level, a press is its falling edge
    always_ff @(posedge CLOCK_50) begin
        if (RESET) key_p2 <= 2'b11;
        else       key_p2 <= key_lvl;
    end

    assign press    = key_p2 & ~key_lvl;
    assign tick     = (state == ST_RUN) && (presc == PW'(TICK_DIV - 1));
    assign last_sec = ({MT, MO, ST} == 12'd0) && (SO == 4'd1);
    assign nonzero  = |{MT, MO, ST, SO};

    always_ff @(posedge CLOCK_50) begin
        if (RESET || press[0]) begin
            presc <= '0;
        end else if (state == ST_RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // Load beats tick beats start/pause; reaching 00:00 overrides a pause press
    always_ff @(posedge CLOCK_50) begin
        if (RESET || press[0]) begin
            state <= ST_IDLE;
        end else if (tick && last_sec) begin
            state <= ST_DONE;
        end else if (press[1]) begin
            case (state)
                ST_IDLE:  state <= nonzero ? ST_RUN : ST_IDLE;
                ST_RUN:   state <= ST_PAUSE;
                ST_PAUSE: state <= ST_RUN;
                default:  state <= state;
            endcase
        end
    end

    bcd_down_digit #(.RST_VAL(bcd_t'(DEFAULT_SO))) u_so (
        .CLOCK_50(CLOCK_50), .rst(RESET), .load(press[0]), .load_val(LOAD_SO),
        .max_val(BCD_MAX_ONES), .dec_in(tick), .digit(SO), .borrow_out(so_b)
    );
    bcd_down_digit #(.RST_VAL(bcd_t'(DEFAULT_ST))) u_st (
        .CLOCK_50(CLOCK_50), .rst(RESET), .load(press[0]), .load_val(LOAD_ST),
        .max_val(BCD_MAX_TENS), .dec_in(so_b), .digit(ST), .borrow_out(st_b)
    );
    bcd_down_digit #(.RST_VAL(bcd_t'(DEFAULT_MO))) u_mo (
        .CLOCK_50(CLOCK_50), .rst(RESET), .load(press[0]), .load_val(LOAD_MO),
        .max_val(BCD_MAX_ONES), .dec_in(st_b), .digit(MO), .borrow_out(mo_b)
    );
    bcd_down_digit #(.RST_VAL(bcd_t'(DEFAULT_MT))) u_mt (
        .CLOCK_50(CLOCK_50), .rst(RESET), .load(press[0]), .load_val(LOAD_MT),
        .max_val(BCD_MAX_TENS), .dec_in(mo_b), .digit(MT), .borrow_out(unused_mt_borrow)
    );

    assign RUNNING = (state == ST_RUN);
    assign DONE    = (state == ST_DONE);

endmodule
